register_file_2r1w: RTL and testbench

- 32-entry x 32-bit general-purpose register file with two read ports and one write port.
- Sits directly upstream of the operand-select mux stage and feeds both ALU operand paths; receives write-back data from the last pipeline stage.
- Each read port selects one of 32 registers through a 32:1 selection network; read results are registered.
- R0 is hardwired to zero; the stack-pointer register has a non-zero reset value.

---
 rtl/register_file_2r1w.sv | 113 +++++++++++
 tb/tb_register_file_2r1w.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/register_file_2r1w.sv
// Purpose: 32 x 32 general-purpose register file, two read ports, one write port, R0 hardwired to zero.
// Latency: one cycle from READ strobe to DATA_R1/DATA_R2/VALID; same-cycle write data is bypassed to readers.
// Backpressure: none; a read is accepted every cycle READ is high, and outputs hold while READ is low.
//
// Ports:
//   CLK, RST          - rising-edge clock, synchronous active-high reset
//   READ, WRITE       - read strobe (samples both read addresses), write strobe
//   ADDR_R1, ADDR_R2  - read register indices; ADDR_W/DATA_W - write index and data
//   DATA_R1, DATA_R2  - registered read data; VALID - outputs carry a read from the previous cycle
module register_file_2r1w #(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    ADDR_WIDTH = 5,
    parameter int                    SP_INDEX   = 29,
    parameter logic [DATA_WIDTH-1:0] SP_RESET   = 32'h03FF_FFFF
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  READ,
    input  logic                  WRITE,
    input  logic [ADDR_WIDTH-1:0] ADDR_R1,
    input  logic [ADDR_WIDTH-1:0] ADDR_R2,
    input  logic [ADDR_WIDTH-1:0] ADDR_W,
    input  logic [DATA_WIDTH-1:0] DATA_W,
    output logic [DATA_WIDTH-1:0] DATA_R1,
    output logic [DATA_WIDTH-1:0] DATA_R2,
    output logic                  VALID
);

    localparam int NUM_REGS = 2 ** ADDR_WIDTH;

    // Storage exists only for R1..R(N-1); R0 is a constant in the read view.
    logic [DATA_WIDTH-1:0] rf_q   [1:NUM_REGS-1];
    logic [DATA_WIDTH-1:0] rf_d   [1:NUM_REGS-1];
    logic [NUM_REGS-1:1]   wr_en;
    logic [DATA_WIDTH-1:0] rf_view [NUM_REGS];

    logic [DATA_WIDTH-1:0] data_r1_q, data_r1_d;
    logic [DATA_WIDTH-1:0] data_r2_q, data_r2_d;
    logic                  valid_q,   valid_d;

    logic [DATA_WIDTH-1:0] src1, src2;

    // Write decode: one enable per writable register, gated by WRITE.
    always_comb begin
        wr_en = '0;
        for (int i = 1; i < NUM_REGS; i++) begin
            wr_en[i] = WRITE && (ADDR_W == ADDR_WIDTH'(i));
        end
    end

    always_comb begin
        for (int i = 1; i < NUM_REGS; i++) begin
            rf_d[i] = wr_en[i] ? DATA_W : rf_q[i];
        end
    end

    always_ff @(posedge CLK) begin
        for (int i = 1; i < NUM_REGS; i++) begin
            if (RST) begin
                rf_q[i] <= (i == SP_INDEX) ? SP_RESET : '0;
            end else begin
                rf_q[i] <= rf_d[i];
            end
        end
    end

    // Full 32-entry view feeding the per-port 32:1 selection.
    always_comb begin
        rf_view[0] = '0;
        for (int i = 1; i < NUM_REGS; i++) begin
            rf_view[i] = rf_q[i];
        end
    end

    // Zero check comes first so a write to R0 can never leak through the bypass.
    function automatic logic [DATA_WIDTH-1:0] read_src(
        input logic [ADDR_WIDTH-1:0] addr,
        input logic [DATA_WIDTH-1:0] sel
    );
        if (addr == '0) begin
            return '0;
        end else if (WRITE && (ADDR_W == addr)) begin
            return DATA_W;
        end else begin
            return sel;
        end
    endfunction

    always_comb begin
        src1      = read_src(ADDR_R1, rf_view[ADDR_R1]);
        src2      = read_src(ADDR_R2, rf_view[ADDR_R2]);
        data_r1_d = READ ? src1 : data_r1_q;
        data_r2_d = READ ? src2 : data_r2_q;
        valid_d   = READ;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            data_r1_q <= '0;
            data_r2_q <= '0;
            valid_q   <= 1'b0;
        end else begin
            data_r1_q <= data_r1_d;
            data_r2_q <= data_r2_d;
            valid_q   <= valid_d;
        end
    end

    assign DATA_R1 = data_r1_q;
    assign DATA_R2 = data_r2_q;
    assign VALID   = valid_q;

endmodule

// File: tb/tb_register_file_2r1w.sv
// Purpose: self-checking bench for register_file_2r1w; directed scenarios plus randomized traffic vs a behavioural model.
// Latency: model predicts outputs one cycle after each sampling edge; outputs compared on every falling edge.
// Backpressure: not applicable; stimulus drives one operation per cycle.
module tb_register_file_2r1w;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic        READ = 1'b0;
    logic        WRITE = 1'b0;
    logic [4:0]  ADDR_R1 = '0;
    logic [4:0]  ADDR_R2 = '0;
    logic [4:0]  ADDR_W = '0;
    logic [31:0] DATA_W = '0;
    logic [31:0] DATA_R1;
    logic [31:0] DATA_R2;
    logic        VALID;

    localparam logic [31:0] SP_RST = 32'h03FF_FFFF;

    register_file_2r1w dut (
        .CLK     (CLK),
        .RST     (RST),
        .READ    (READ),
        .WRITE   (WRITE),
        .ADDR_R1 (ADDR_R1),
        .ADDR_R2 (ADDR_R2),
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .DATA_R1 (DATA_R1),
        .DATA_R2 (DATA_R2),
        .VALID   (VALID)
    );

    always #5 CLK = ~CLK;

    int vectors = 0;
    int miscompares = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Behavioural model: an array of registers plus the last read results.
    logic [31:0] m_rf [32];
    logic [31:0] m_r1 = '0;
    logic [31:0] m_r2 = '0;
    logic        m_vld = 1'b0;
    bit          model_ok = 1'b0;

    function automatic logic [31:0] m_src(input logic [4:0] a);
        if (a == 5'd0) return 32'h0;
        if (WRITE && ADDR_W == a) return DATA_W;
        return m_rf[a];
    endfunction

    always @(posedge CLK) begin
        logic [31:0] s1, s2;
        if (RST) begin
            for (int k = 0; k < 32; k++) m_rf[k] = 32'h0;
            m_rf[29] = SP_RST;
            m_r1     = 32'h0;
            m_r2     = 32'h0;
            m_vld    = 1'b0;
            model_ok = 1'b1;
        end else begin
            s1 = m_src(ADDR_R1);
            s2 = m_src(ADDR_R2);
            if (READ) begin
                m_r1 = s1;
                m_r2 = s2;
            end
            m_vld = READ;
            if (WRITE && ADDR_W != 5'd0) m_rf[ADDR_W] = DATA_W;
        end
    end

    // Every cycle after the first reset, the DUT must match the model.
    always @(negedge CLK) begin
        if (model_ok) begin
            check("model_data_r1", DATA_R1, m_r1);
            check("model_data_r2", DATA_R2, m_r2);
            check("model_valid", {31'h0, VALID}, {31'h0, m_vld});
        end
    end

    task automatic cyc(input logic rst, input logic rd, input logic wr,
                       input logic [4:0] a1, input logic [4:0] a2, input logic [4:0] aw,
                       input logic [31:0] dw);
        RST = rst; READ = rd; WRITE = wr;
        ADDR_R1 = a1; ADDR_R2 = a2; ADDR_W = aw; DATA_W = dw;
        @(negedge CLK);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        logic [4:0]  a1, a2, aw;
        logic [31:0] exp1, exp2;
        @(negedge CLK);

        // Reset state and SP reset value
        cyc(1, 0, 0, 0, 0, 0, 0);
        check("rst_valid", {31'h0, VALID}, 32'h0);
        check("rst_r1", DATA_R1, 32'h0);
        cyc(0, 1, 0, 5'd29, 5'd5, 0, 0);
        check("sp_reset_r1", DATA_R1, 32'h03FF_FFFF);
        check("sp_reset_r2", DATA_R2, 32'h0);
        check("sp_reset_valid", {31'h0, VALID}, 32'h1);

        // Write then read back on both ports
        cyc(0, 0, 1, 0, 0, 5'd7, 32'hDEAD_BEEF);
        cyc(0, 1, 0, 5'd7, 5'd7, 0, 0);
        check("wr7_r1", DATA_R1, 32'hDEAD_BEEF);
        check("wr7_r2", DATA_R2, 32'hDEAD_BEEF);

        // Fill all writable registers, read everything back with crossed ports
        for (int i = 1; i < 32; i++) cyc(0, 0, 1, 0, 0, 5'(i), 32'h1000_0000 + i);
        for (int i = 0; i < 32; i++) begin
            cyc(0, 1, 0, 5'(i), 5'(31 - i), 0, 0);
            exp1 = (i == 0) ? 32'h0 : 32'h1000_0000 + i;
            exp2 = (i == 31) ? 32'h0 : 32'h1000_0000 + (31 - i);
            check("fill_r1", DATA_R1, exp1);
            check("fill_r2", DATA_R2, exp2);
        end

        // R0 protection, same cycle and following cycle
        cyc(0, 1, 1, 5'd0, 5'd0, 5'd0, 32'hFFFF_FFFF);
        check("r0_same", DATA_R1, 32'h0);
        cyc(0, 1, 0, 5'd0, 5'd0, 0, 0);
        check("r0_after", DATA_R1, 32'h0);

        // Write-through bypass
        cyc(0, 0, 1, 0, 0, 5'd3, 32'h1111_1111);
        cyc(0, 1, 1, 5'd3, 5'd4, 5'd3, 32'h2222_2222);
        check("bypass_r1", DATA_R1, 32'h2222_2222);
        check("bypass_r2", DATA_R2, 32'h1000_0004);
        cyc(0, 1, 0, 5'd3, 5'd3, 0, 0);
        check("bypass_later", DATA_R1, 32'h2222_2222);

        // Hold while idle, even with a matching write
        cyc(0, 1, 0, 5'd3, 5'd3, 0, 0);
        check("hold_v1", {31'h0, VALID}, 32'h1);
        for (int i = 0; i < 3; i++) begin
            cyc(0, 0, 1, 5'd3, 5'd3, 5'd3, 32'h5555_5555);
            check("hold_r1", DATA_R1, 32'h2222_2222);
            check("hold_v0", {31'h0, VALID}, 32'h0);
        end

        // Reset overrides a simultaneous write and read
        cyc(1, 1, 1, 5'd9, 5'd9, 5'd9, 32'hABCD_0001);
        check("rstmid_valid", {31'h0, VALID}, 32'h0);
        check("rstmid_r1", DATA_R1, 32'h0);
        check("rstmid_r2", DATA_R2, 32'h0);
        cyc(0, 1, 0, 5'd9, 5'd29, 0, 0);
        check("rstmid_r9", DATA_R1, 32'h0);
        check("rstmid_sp", DATA_R2, 32'h03FF_FFFF);

        // Randomized traffic with frequent address collisions
        for (int n = 0; n < 3000; n++) begin
            aw = 5'($urandom_range(0, 31));
            a1 = ($urandom_range(0, 3) == 0) ? aw : 5'($urandom_range(0, 31));
            a2 = ($urandom_range(0, 3) == 0) ? a1 : 5'($urandom_range(0, 31));
            cyc(($urandom_range(0, 99) == 0), ($urandom_range(0, 3) != 0),
                1'($urandom_range(0, 1)), a1, a2, aw, $urandom);
        end

        cyc(0, 0, 0, 0, 0, 0, 0);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
